// File: rtl/qs_stream_ctrl.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// qs_stream_ctrl
//
// Purpose:
//   Sequencer and stream adapter in front of the quicksort engine. One accepted
//   ap_start runs one job. The job kicks the engine, streams exactly NUM_WORDS
//   words from the slave stream into the engine's load phase, and waits while
//   the engine sorts. It then drains the sorted words onto the master stream.
//   The block reports idle/done status, a sticky TLAST-mismatch flag and the
//   number of cycles spent waiting for the sort.
//
// Ports:
//   clk, reset_n        system clock, asynchronous active-low reset (shared
//                       with the engine)
//   ap_start            job request, honoured only in IDLE with the engine idle
//   ap_idle             high while the sequencer is in IDLE
//   ap_done             level; set on the last output beat, cleared by the next
//                       accepted ap_start
//   err_tlast           sticky; input TLAST did not mark exactly the last word
//   sort_cycles         saturating length of the last job's SORT phase
//   ss_*                slave stream (tvalid/tdata/tlast in, tready out)
//   sm_*                master stream (tvalid/tdata/tlast out, tready in)
//   qs_start            one-cycle engine start strobe
//   qs_data_in          word presented to the engine during LOAD
//   qs_data_en          engine load/drain strobe, one per transferred word
//   qs_data_out         sorted word presented by the engine during drain
//   qs_dir / qs_dor     engine accepts data / engine presents data
//   qs_idle / qs_done   engine status flags
// -----------------------------------------------------------------------------
module qs_stream_ctrl #(
  parameter int pDATA_WIDTH = 32,
  parameter int NUM_WORDS   = 11,
  parameter int pCNT_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  // control / status
  input  logic                   ap_start,
  output logic                   ap_idle,
  output logic                   ap_done,
  output logic                   err_tlast,
  output logic [pCNT_WIDTH-1:0]  sort_cycles,
  // slave stream
  input  logic                   ss_tvalid,
  input  logic [pDATA_WIDTH-1:0] ss_tdata,
  input  logic                   ss_tlast,
  output logic                   ss_tready,
  // master stream
  output logic                   sm_tvalid,
  output logic [pDATA_WIDTH-1:0] sm_tdata,
  output logic                   sm_tlast,
  input  logic                   sm_tready,
  // quicksort engine
  output logic                   qs_start,
  output logic [pDATA_WIDTH-1:0] qs_data_in,
  output logic                   qs_data_en,
  input  logic [pDATA_WIDTH-1:0] qs_data_out,
  input  logic                   qs_dir,
  input  logic                   qs_dor,
  input  logic                   qs_idle,
  input  logic                   qs_done
);

  // Word counter must be able to represent NUM_WORDS itself.
  localparam int CW = $clog2(NUM_WORDS + 1);

  localparam logic [CW-1:0]         CNT_LIMIT = CW'(NUM_WORDS);
  localparam logic [CW-1:0]         CNT_LAST  = CW'(NUM_WORDS - 1);
  localparam logic [CW-1:0]         CNT_ONE   = CW'(1);
  localparam logic [pCNT_WIDTH-1:0] CYC_ONE   = pCNT_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_KICK,
    S_LOAD,
    S_SORT,
    S_DRAIN
  } state_t;

  state_t                r_state,       w_state_nxt;
  logic [CW-1:0]         r_count,       w_count_nxt;
  logic [pCNT_WIDTH-1:0] r_cyc,         w_cyc_nxt;
  logic [pCNT_WIDTH-1:0] r_sort_cycles, w_sort_cycles_nxt;
  logic                  r_done,        w_done_nxt;
  logic                  r_err,         w_err_nxt;

  logic [pCNT_WIDTH-1:0] w_cyc_inc;
  logic                  w_is_last;
  logic                  w_ld_hs;
  logic                  w_dr_hs;

  // The drain is paced purely by qs_dor; the engine's done flag carries no
  // extra information for this sequencer.
  logic w_unused_qs_done;
  assign w_unused_qs_done = qs_done;

  // Data paths are straight wires; the valid/enable strobes qualify them.
  assign qs_data_in = ss_tdata;
  assign sm_tdata   = qs_data_out;

  assign ap_idle     = (r_state == S_IDLE);
  assign ap_done     = r_done;
  assign err_tlast   = r_err;
  assign sort_cycles = r_sort_cycles;

  assign w_is_last = (r_count == CNT_LAST);

  // Saturating increment: the counter sticks at all-ones on very long sorts.
  assign w_cyc_inc = (&r_cyc) ? r_cyc : (r_cyc + CYC_ONE);

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    w_state_nxt       = r_state;
    w_count_nxt       = r_count;
    w_cyc_nxt         = r_cyc;
    w_sort_cycles_nxt = r_sort_cycles;
    w_done_nxt        = r_done;
    w_err_nxt         = r_err;
    ss_tready         = 1'b0;
    sm_tvalid         = 1'b0;
    sm_tlast          = 1'b0;
    qs_start          = 1'b0;
    qs_data_en        = 1'b0;
    w_ld_hs           = 1'b0;
    w_dr_hs           = 1'b0;

    case (r_state)
      S_IDLE: begin
        // A request while the engine is still busy is dropped, not queued.
        if (ap_start && qs_idle) begin
          w_state_nxt = S_KICK;
          w_done_nxt  = 1'b0;
          w_err_nxt   = 1'b0;
          w_count_nxt = '0;
        end
      end

      S_KICK: begin
        qs_start    = 1'b1;
        w_state_nxt = S_LOAD;
      end

      S_LOAD: begin
        ss_tready  = qs_dir && (r_count < CNT_LIMIT);
        w_ld_hs    = ss_tvalid && ss_tready;
        qs_data_en = w_ld_hs;
        if (w_ld_hs) begin
          // TLAST is only audited; the word count alone ends the load.
          if (ss_tlast != w_is_last) begin
            w_err_nxt = 1'b1;
          end
          if (w_is_last) begin
            w_state_nxt = S_SORT;
            w_count_nxt = '0;
            w_cyc_nxt   = '0;
          end else begin
            w_count_nxt = r_count + CNT_ONE;
          end
        end
      end

      S_SORT: begin
        // sort_cycles counts every SORT cycle, including the one that sees
        // qs_dor, so the reported value is never zero.
        w_cyc_nxt = w_cyc_inc;
        if (qs_dor) begin
          w_sort_cycles_nxt = w_cyc_inc;
          w_state_nxt       = S_DRAIN;
        end
      end

      S_DRAIN: begin
        sm_tvalid  = qs_dor && (r_count < CNT_LIMIT);
        sm_tlast   = sm_tvalid && w_is_last;
        w_dr_hs    = sm_tvalid && sm_tready;
        qs_data_en = w_dr_hs;
        if (w_dr_hs) begin
          if (w_is_last) begin
            w_done_nxt  = 1'b1;
            w_count_nxt = '0;
            w_state_nxt = S_IDLE;
          end else begin
            w_count_nxt = r_count + CNT_ONE;
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_count       <= '0;
      r_cyc         <= '0;
      r_sort_cycles <= '0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // values from before this edge, independent of statement order.
      r_state       <= w_state_nxt;
      r_count       <= w_count_nxt;
      r_cyc         <= w_cyc_nxt;
      r_sort_cycles <= w_sort_cycles_nxt;
      r_done        <= w_done_nxt;
      r_err         <= w_err_nxt;
    end
  end

endmodule

// File: tb/tb_qs_stream_ctrl.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// tb_qs_stream_ctrl
//
// Drives qs_stream_ctrl against a behavioural quicksort engine. The expected
// output of every job is the input list sorted by a queue sort. The expected
// TLAST flag follows from where TLAST was placed. The expected sort_cycles is
// the engine's busy time plus its done-only cycle plus the cycle in which DOR
// is first seen, saturated to the counter width. A narrow counter is used so
// that saturation is reachable.
// -----------------------------------------------------------------------------
module tb_qs_stream_ctrl;

  localparam int DW      = 32;
  localparam int N       = 11;
  localparam int CW      = 4;
  localparam int CYC_MAX = (1 << CW) - 1;
  localparam int BUDGET  = 400;

  typedef logic [DW-1:0] word_arr_t [N];

  logic          clk;
  logic          reset_n;
  logic          ap_start;
  logic          ap_idle;
  logic          ap_done;
  logic          err_tlast;
  logic [CW-1:0] sort_cycles;
  logic          ss_tvalid;
  logic [DW-1:0] ss_tdata;
  logic          ss_tlast;
  logic          ss_tready;
  logic          sm_tvalid;
  logic [DW-1:0] sm_tdata;
  logic          sm_tlast;
  logic          sm_tready;
  logic          qs_start;
  logic [DW-1:0] qs_data_in;
  logic          qs_data_en;
  logic [DW-1:0] qs_data_out;
  logic          qs_dir;
  logic          qs_dor;
  logic          qs_idle;
  logic          qs_done;

  int n_checks;
  int n_errors;

  qs_stream_ctrl #(
    .pDATA_WIDTH(DW),
    .NUM_WORDS  (N),
    .pCNT_WIDTH (CW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ap_start   (ap_start),
    .ap_idle    (ap_idle),
    .ap_done    (ap_done),
    .err_tlast  (err_tlast),
    .sort_cycles(sort_cycles),
    .ss_tvalid  (ss_tvalid),
    .ss_tdata   (ss_tdata),
    .ss_tlast   (ss_tlast),
    .ss_tready  (ss_tready),
    .sm_tvalid  (sm_tvalid),
    .sm_tdata   (sm_tdata),
    .sm_tlast   (sm_tlast),
    .sm_tready  (sm_tready),
    .qs_start   (qs_start),
    .qs_data_in (qs_data_in),
    .qs_data_en (qs_data_en),
    .qs_data_out(qs_data_out),
    .qs_dir     (qs_dir),
    .qs_dor     (qs_dor),
    .qs_idle    (qs_idle),
    .qs_done    (qs_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Behavioural engine: idle -> accept N words -> busy for sort_delay cycles
  // -> one done-only cycle -> present sorted words, advancing on each strobe.
  // ---------------------------------------------------------------------------
  int        e_phase;
  int        e_wr;
  int        e_idx;
  int        e_cnt;
  int        e_jobs;
  int        sort_delay;
  bit        eng_block;
  word_arr_t e_buf;
  word_arr_t e_sorted;

  function automatic word_arr_t engine_sort(input word_arr_t a);
    word_arr_t     r;
    logic [DW-1:0] t;
    r = a;
    for (int i = 0; i < N - 1; i++) begin
      for (int j = 0; j < N - 1 - i; j++) begin
        if (r[j] > r[j+1]) begin
          t      = r[j];
          r[j]   = r[j+1];
          r[j+1] = t;
        end
      end
    end
    return r;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e_phase <= 0;
      e_wr    <= 0;
      e_idx   <= 0;
      e_cnt   <= 0;
    end else begin
      case (e_phase)
        0: if (qs_start) begin
          e_phase <= 1;
          e_wr    <= 0;
          e_jobs  <= e_jobs + 1;
        end
        1: if (qs_data_en) begin
          e_buf[e_wr] <= qs_data_in;
          e_wr        <= e_wr + 1;
          if (e_wr == N - 1) begin
            e_phase <= 2;
            e_cnt   <= sort_delay;
          end
        end
        2: if (e_cnt <= 1) e_phase <= 3;
           else            e_cnt   <= e_cnt - 1;
        3: begin
          e_sorted <= engine_sort(e_buf);
          e_idx    <= 0;
          e_phase  <= 4;
        end
        4: if (qs_data_en) begin
          if (e_idx == N - 1) e_phase <= 0;
          e_idx <= e_idx + 1;
        end
        default: e_phase <= 0;
      endcase
    end
  end

  assign qs_idle     = (e_phase == 0) && !eng_block;
  assign qs_dir      = (e_phase == 1);
  assign qs_dor      = (e_phase == 4);
  assign qs_done     = (e_phase >= 3);
  assign qs_data_out = (e_phase == 4) ? e_sorted[e_idx] : '0;

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One complete job. Called just after a falling edge; returns just after a
  // falling edge. tlast_pos < 0 places TLAST correctly on the last word.
  task automatic run_job(input word_arr_t words, input int tlast_pos,
                         input int gap_pct, input int rdy_pct, input int stall_at,
                         input int delay, input bit busy_pulse, input int abort_beat);
    logic [DW-1:0] exp_q[$];
    bit            exp_err;
    int            exp_cyc;
    int            jobs0;
    int            idx;
    int            k;
    int            cyc;
    int            stall_left;
    bit            stalled;
    bit            v;
    bit            rdy;

    for (int i = 0; i < N; i++) exp_q.push_back(words[i]);
    exp_q.sort();
    exp_err    = (tlast_pos >= 0) && (tlast_pos != N - 1);
    exp_cyc    = (delay + 2 > CYC_MAX) ? CYC_MAX : delay + 2;
    jobs0      = e_jobs;
    sort_delay = delay;
    sm_tready  = 1'b1;

    // Start request; accepted on the next rising edge.
    ap_start = 1'b1;
    @(negedge clk);
    ap_start = 1'b0;
    #1;
    check("kick_qs_start", qs_start, 1'b1);
    check("kick_done_clr", ap_done, 1'b0);
    check("kick_err_clr", err_tlast, 1'b0);
    check("kick_not_idle", ap_idle, 1'b0);
    check("kick_tready", ss_tready, 1'b0);
    @(negedge clk);
    #1;
    check("load_first_ready", ss_tready, 1'b1);
    check("load_qs_start_low", qs_start, 1'b0);

    // Load phase.
    idx = 0;
    cyc = 0;
    while (idx < N && cyc < BUDGET) begin
      v         = (gap_pct == 0) || ($urandom_range(99) >= gap_pct);
      ss_tvalid = v;
      ss_tdata  = words[idx];
      ss_tlast  = (tlast_pos < 0) ? (idx == N - 1) : (idx == tlast_pos);
      if (v && idx == abort_beat) begin
        reset_n = 1'b0;
        #1;
        check("abort_idle", ap_idle, 1'b1);
        check("abort_tready", ss_tready, 1'b0);
        check("abort_sm_valid", sm_tvalid, 1'b0);
        check("abort_done", ap_done, 1'b0);
        check("abort_en", qs_data_en, 1'b0);
        check("abort_sort_cycles", sort_cycles, 0);
        ss_tvalid = 1'b0;
        ss_tlast  = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        return;
      end
      #1;
      check("load_ready", ss_tready, 1'b1);
      check("load_en", qs_data_en, v);
      if (v) check("load_data", qs_data_in, words[idx]);
      if (v) idx++;
      @(negedge clk);
      cyc++;
    end
    ss_tvalid = 1'b0;
    ss_tlast  = 1'b0;
    check("load_beats", idx, N);

    // Sort phase: wait for the first output beat.
    cyc = 0;
    #1;
    while (!sm_tvalid && cyc < BUDGET) begin
      check("sort_tready_low", ss_tready, 1'b0);
      check("sort_en_low", qs_data_en, 1'b0);
      check("sort_busy", ap_idle, 1'b0);
      if (busy_pulse) ap_start = 1'b1;
      @(negedge clk);
      #1;
      cyc++;
    end
    ap_start = 1'b0;
    check("sort_to_drain", sm_tvalid, 1'b1);

    // Drain phase.
    k          = 0;
    cyc        = 0;
    stall_left = 0;
    stalled    = 1'b0;
    while (k < N && cyc < BUDGET) begin
      if (k == stall_at && !stalled) begin
        stalled    = 1'b1;
        stall_left = 5;
      end
      if (stall_left > 0) begin
        rdy = 1'b0;
        stall_left--;
      end else begin
        rdy = (rdy_pct == 0) || ($urandom_range(99) >= rdy_pct);
      end
      sm_tready = rdy;
      #1;
      check("drain_valid", sm_tvalid, 1'b1);
      check("drain_data", sm_tdata, exp_q[k]);
      check("drain_last", sm_tlast, k == N - 1);
      check("drain_en", qs_data_en, rdy);
      check("drain_in_ready", ss_tready, 1'b0);
      if (rdy) k++;
      @(negedge clk);
      #1;
      cyc++;
    end
    sm_tready = 1'b1;
    check("drain_beats", k, N);
    check("end_no_extra_beat", sm_tvalid, 1'b0);
    check("end_done", ap_done, 1'b1);
    check("end_idle", ap_idle, 1'b1);
    check("end_err_tlast", err_tlast, exp_err);
    check("end_sort_cycles", sort_cycles, exp_cyc);
    check("end_one_job", e_jobs, jobs0 + 1);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence with randomized data, gaps and backpressure
  // ---------------------------------------------------------------------------
  word_arr_t w;
  int        jobs_before;

  initial begin
    ap_start   = 1'b0;
    ss_tvalid  = 1'b0;
    ss_tdata   = '0;
    ss_tlast   = 1'b0;
    sm_tready  = 1'b1;
    eng_block  = 1'b0;
    sort_delay = 1;
    reset_n    = 1'b1;
    #2 reset_n = 1'b0;
    #6;
    check("rst_idle", ap_idle, 1'b1);
    check("rst_done", ap_done, 1'b0);
    check("rst_err", err_tlast, 1'b0);
    check("rst_sort_cycles", sort_cycles, 0);
    check("rst_tready", ss_tready, 1'b0);
    check("rst_sm_valid", sm_tvalid, 1'b0);
    check("rst_sm_last", sm_tlast, 1'b0);
    check("rst_qs_start", qs_start, 1'b0);
    check("rst_qs_en", qs_data_en, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Basic job, back-to-back input, full-rate output.
    w = '{32'd5, 32'd3, 32'd9, 32'd1, 32'd7, 32'd2, 32'd8, 32'd6, 32'd4, 32'd10, 32'd0};
    run_job(w, -1, 0, 0, -1, 3, 1'b0, -1);

    // Same data with input gaps and a five-cycle stall mid-drain.
    run_job(w, -1, 40, 0, 4, 6, 1'b0, -1);

    // Early TLAST on word 4 flags the error but still loads all words.
    for (int i = 0; i < N; i++) w[i] = $urandom;
    run_job(w, 4, 20, 0, -1, 2, 1'b0, -1);

    // A clean job clears the sticky flag.
    for (int i = 0; i < N; i++) w[i] = $urandom_range(0, 63);
    run_job(w, -1, 0, 20, -1, 4, 1'b0, -1);

    // Start requests during SORT are ignored; all-equal data.
    for (int i = 0; i < N; i++) w[i] = 32'd7;
    run_job(w, -1, 0, 0, -1, 5, 1'b1, -1);

    // Start while the engine reports busy is dropped.
    jobs_before = e_jobs;
    eng_block   = 1'b1;
    ap_start    = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1;
      check("blocked_idle", ap_idle, 1'b1);
      check("blocked_no_kick", qs_start, 1'b0);
      check("blocked_tready", ss_tready, 1'b0);
    end
    ap_start  = 1'b0;
    eng_block = 1'b0;
    check("blocked_jobs", e_jobs, jobs_before);

    // Reset during the sixth load beat, then a full job.
    for (int i = 0; i < N; i++) w[i] = $urandom;
    run_job(w, -1, 0, 0, -1, 3, 1'b0, 5);
    run_job(w, -1, 30, 30, -1, 7, 1'b0, -1);

    // Long sort saturates the counter; the next job starts the cycle after
    // ap_done rises and reports its own count.
    for (int i = 0; i < N; i++) w[i] = $urandom_range(0, 1000);
    run_job(w, -1, 0, 0, -1, 20, 1'b0, -1);
    for (int i = 0; i < N; i++) w[i] = $urandom_range(0, 1000);
    run_job(w, -1, 0, 0, -1, 1, 1'b0, -1);

    // A few fully random jobs.
    for (int j = 0; j < 3; j++) begin
      for (int i = 0; i < N; i++) w[i] = $urandom_range(0, 15);
      run_job(w, -1, 35, 35, $urandom_range(0, N - 1), $urandom_range(1, 12), 1'b0, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/qs_stream_ctrl.md
Name: qs_stream_ctrl

Overview:
- Sequencer and stream adapter in front of the quicksort engine in the user project.
- Takes one start command, feeds exactly NUM_WORDS words from an AXI-Stream-style slave port into the engine's load phase, and waits for the sort to finish.
- Then drains the sorted words onto an AXI-Stream-style master port.
- Reports idle/done status, a sticky TLAST-mismatch error and the sort-phase cycle count.

Parameters:
- pDATA_WIDTH, 32, stream and engine data width
- NUM_WORDS, 11, words per sort job; must equal the engine's queue depth
- pCNT_WIDTH, 16, width of the sort-cycle counter

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- ap_start  in  1  job start request, sampled only in IDLE
- ap_idle  out  1  high in IDLE
- ap_done  out  1  level, set when the last output word is accepted; cleared by the next accepted ap_start
- err_tlast  out  1  sticky TLAST mismatch; cleared by an accepted ap_start
- sort_cycles  out  pCNT_WIDTH  cycles spent in SORT for the last job
- ss_tvalid  in  1  input word valid
- ss_tdata  in  pDATA_WIDTH  input word
- ss_tlast  in  1  input last marker
- ss_tready  out  1  input ready
- sm_tvalid  out  1  output word valid
- sm_tdata  out  pDATA_WIDTH  output word
- sm_tlast  out  1  high on the final output word
- sm_tready  in  1  downstream ready
- qs_start  out  1  engine start_fg
- qs_data_in  out  pDATA_WIDTH  engine QS_data_in
- qs_data_en  out  1  engine QS_data_en, the load/drain strobe
- qs_data_out  in  pDATA_WIDTH  engine QS_data_out
- qs_dir  in  1  engine DIR_fg (engine accepts data)
- qs_dor  in  1  engine DOR_fg (engine presents data)
- qs_idle  in  1  engine idle_fg
- qs_done  in  1  engine done_fg

Behaviour:
- Clock and reset: one clock, clk. Reset reset_n is asynchronous, active-low.
- Reset values:
  - State is IDLE.
  - ap_idle=1; ap_done=0; err_tlast=0; sort_cycles=0.
  - ss_tready=0; sm_tvalid=0; sm_tlast=0; qs_start=0; qs_data_en=0.
  - Word counter is 0.
  - Asserting reset mid-job aborts the job immediately; the engine shares reset_n, so both return to idle with no drain.
- FSM states: IDLE, KICK, LOAD, SORT, DRAIN.
- IDLE:
  - Transition to KICK requires ap_start=1 and qs_idle=1.
  - On that transition: ap_done and err_tlast are cleared, and the counter is cleared.
  - If ap_start is high while qs_idle=0, the request is ignored.
- KICK:
  - qs_start=1 for exactly one cycle.
  - Next state is LOAD.
- LOAD:
  - ss_tready = qs_dir and (count < NUM_WORDS), combinational.
  - qs_data_in = ss_tdata, passed through combinationally.
  - qs_data_en = ss_tvalid and ss_tready.
  - Each handshake increments count.
  - TLAST check: if ss_tlast=1 on word index < NUM_WORDS-1, or ss_tlast=0 on index NUM_WORDS-1, set err_tlast.
  - Word count alone governs the transfer; TLAST never ends LOAD early or late.
  - When count reaches NUM_WORDS: go to SORT, clear count, clear the cycle counter.
- SORT:
  - ss_tready=0.
  - The cycle counter increments every cycle and saturates at all-ones.
  - On qs_dor=1: latch the counter into sort_cycles and go to DRAIN.
  - qs_done without qs_dor stays in SORT.
- DRAIN:
  - sm_tvalid = qs_dor and (count < NUM_WORDS).
  - sm_tdata = qs_data_out, combinational.
  - sm_tlast = sm_tvalid and (count == NUM_WORDS-1).
  - qs_data_en = sm_tvalid and sm_tready; each handshake increments count.
  - sm_tdata must hold stable while sm_tvalid=1 and sm_tready=0.
  - After the handshake with count == NUM_WORDS-1: set ap_done and go to IDLE.
- Stall rules:
  - Backpressure (sm_tready=0) and input gaps (ss_tvalid=0) of any length are tolerated; no data is lost or duplicated.
  - qs_data_en is never asserted outside LOAD or DRAIN.
- Throughput:
  - Peak is one word per cycle in both LOAD and DRAIN.
  - End-to-end latency from ap_start to first input accept is 2 cycles (IDLE→KICK→LOAD, plus the engine's IDLE→DTPR step).
- Widths: count is wide enough to hold NUM_WORDS. sort_cycles is unsigned and saturating.

Test Plan:
- Basic job: ap_start, feed 11 words [5,3,9,1,7,2,8,6,4,10,0] back-to-back with tlast on the 11th → sm emits 0..10 in order, tlast only on 10, ap_done=1, err_tlast=0, sort_cycles>0.
- Throttling: random ss_tvalid gaps plus sm_tready held low for 5 cycles mid-drain → identical sorted output, sm_tdata stable during the stall, exactly 11 output beats.
- TLAST errors:
  - Job 1: tlast on word 4 → err_tlast=1, all 11 words still loaded, output correct.
  - Job 2: ap_start then tlast correct → err_tlast cleared to 0.
- Busy and duplicate data: ap_start pulsed again during SORT → ignored, exactly one job. Duplicates [7×11] → eleven 7s out.
- Reset mid-job: assert reset_n=0 during the 6th LOAD beat → ap_idle=1, ss_tready=0, sm_tvalid=0, ap_done=0. The next full job completes correctly.
- Back-to-back jobs: second ap_start the cycle after ap_done rises → ap_done clears, second job sorts independently, and sort_cycles is updated with the second job's count.
